// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data over fetch, with starvation guard.
// Optional grant watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        arb_err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    IGNT,
    DGNT
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          d_req;
  logic          starved;
  logic          wd_hit;
  logic          tmo_fire;

  assign d_req   = dREN | dWEN;
  assign starved = iREN && (starve_cnt_q == SLIM);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_fire     = 1'b0;
    ihit         = 1'b0;
    iload        = '0;
    dhit         = 1'b0;
    dload        = '0;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    // Outputs are forced quiet while RST is high so an access aborts at once.
    if (!RST) begin
      unique case (state_q)
        IDLE: begin
          if (d_req && !starved) begin
            state_d = DGNT;
          end else if (iREN) begin
            state_d = IGNT;
          end
        end
        IGNT: begin
          if (!iREN) begin
            state_d = IDLE;
          end else begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (ram_ready) begin
              ihit         = 1'b1;
              iload        = ramload;
              state_d      = IDLE;
              starve_cnt_d = '0;
            end else if (wd_hit) begin
              tmo_fire = 1'b1;
              state_d  = IDLE;
            end
          end
        end
        DGNT: begin
          if (!d_req) begin
            state_d = IDLE;
          end else begin
            ramREN   = dREN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (ram_ready) begin
              dhit    = 1'b1;
              dload   = dREN ? ramload : '0;
              state_d = IDLE;
              if (!iREN) begin
                starve_cnt_d = '0;
              end else if (starve_cnt_q != SLIM) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
              end
            end else if (wd_hit) begin
              tmo_fire = 1'b1;
              state_d  = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT - 1);

  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic          arb_err_q, arb_err_d;

  assign wd_hit  = (wd_cnt_q == WLIM) && !ram_ready;
  assign arb_err = arb_err_q;

  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    arb_err_d = arb_err_q | tmo_fire;
    // Counts only while a grant is live; any return to IDLE restarts it.
    if (state_q == IDLE || state_d == IDLE) begin
      wd_cnt_d = '0;
    end else if (!ram_ready) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt_q  <= '0;
      arb_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      arb_err_q <= arb_err_d;
    end
  end
`else
  logic unused_cfg;

  assign wd_hit     = 1'b0;
  assign arb_err    = 1'b0;
  assign unused_cfg = ^{TIMEOUT, tmo_fire};
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, contention, write,
// starvation, abort, reset mid-access and grant watchdog.
module tb_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ihit;
  logic [31:0] iload;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  logic        arb_err;

  int n_vec;
  int n_err;

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT     (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .ihit     (ihit),
    .iload    (iload),
    .dhit     (dhit),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_ready(ram_ready),
    .arb_err  (arb_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    RST       = 1'b1;
    iREN      = 1'b1;
    dREN      = 1'b1;
    dWEN      = 1'b0;
    iaddr     = '0;
    daddr     = '0;
    dstore    = '0;
    ramload   = '0;
    ram_ready = 1'b0;

    // reset held two cycles with requests up
    nxt(); smp();
    chk("rst_ren", {31'd0, ramREN}, 0);
    chk("rst_hit", {30'd0, ihit, dhit}, 0);
    nxt(); smp();
    chk("rst_wen", {31'd0, ramWEN}, 0);
    chk("rst_err", {31'd0, arb_err}, 0);
    chk("rst_addr", ramaddr, 0);
    RST  = 1'b0;
    iREN = 1'b0;
    dREN = 1'b0;
    nxt(); smp();
    chk("idle_ren", {31'd0, ramREN}, 0);

    // fetch only
    nxt();
    iREN  = 1'b1;
    iaddr = 32'h40;
    smp();
    chk("f0_ren", {31'd0, ramREN}, 0);
    nxt(); smp();
    chk("f1_ren", {31'd0, ramREN}, 1);
    chk("f1_addr", ramaddr, 32'h40);
    chk("f1_hit", {31'd0, ihit}, 0);
    nxt(); smp();
    chk("f2_ren", {31'd0, ramREN}, 1);
    nxt();
    ram_ready = 1'b1;
    ramload   = 32'h8C010004;
    smp();
    chk("f3_ren", {31'd0, ramREN}, 1);
    chk("f3_ihit", {31'd0, ihit}, 1);
    chk("f3_iload", iload, 32'h8C010004);
    nxt();
    ram_ready = 1'b0;
    iREN      = 1'b0;
    smp();
    chk("f4_ren", {31'd0, ramREN}, 0);
    chk("f4_iload", iload, 0);

    // contention: data first, then fetch
    nxt();
    iREN  = 1'b1;
    iaddr = 32'h44;
    dREN  = 1'b1;
    daddr = 32'h200;
    smp();
    chk("c0_ren", {31'd0, ramREN}, 0);
    nxt();
    ram_ready = 1'b1;
    ramload   = 32'h11;
    smp();
    chk("c1_addr", ramaddr, 32'h200);
    chk("c1_dhit", {31'd0, dhit}, 1);
    chk("c1_ihit", {31'd0, ihit}, 0);
    chk("c1_dload", dload, 32'h11);
    nxt();
    ram_ready = 1'b0;
    dREN      = 1'b0;
    smp();
    chk("c2_ren", {31'd0, ramREN}, 0);
    nxt();
    ram_ready = 1'b1;
    ramload   = 32'h22;
    smp();
    chk("c3_addr", ramaddr, 32'h44);
    chk("c3_ihit", {31'd0, ihit}, 1);
    chk("c3_iload", iload, 32'h22);
    nxt();
    ram_ready = 1'b0;
    iREN      = 1'b0;

    // data write
    nxt();
    dWEN   = 1'b1;
    daddr  = 32'h100;
    dstore = 32'hDEADBEEF;
    smp();
    chk("w0_wen", {31'd0, ramWEN}, 0);
    nxt(); smp();
    chk("w1_wen", {31'd0, ramWEN}, 1);
    chk("w1_ren", {31'd0, ramREN}, 0);
    chk("w1_addr", ramaddr, 32'h100);
    chk("w1_store", ramstore, 32'hDEADBEEF);
    chk("w1_dhit", {31'd0, dhit}, 0);
    nxt();
    ram_ready = 1'b1;
    ramload   = 32'h33;
    smp();
    chk("w2_dhit", {31'd0, dhit}, 1);
    chk("w2_dload", dload, 0);
    nxt();
    ram_ready = 1'b0;
    dWEN      = 1'b0;
    smp();
    chk("w3_wen", {31'd0, ramWEN}, 0);

    // starvation: four data grants, then fetch
    nxt();
    iREN      = 1'b1;
    dREN      = 1'b1;
    ram_ready = 1'b1;
    ramload   = 32'hA5;
    smp();
    chk("s_idle0", {30'd0, ihit, dhit}, 0);
    for (int k = 0; k < 5; k++) begin
      nxt(); smp();
      chk($sformatf("s_g%0d", k), {30'd0, ihit, dhit},
          (k < 4) ? 32'd1 : 32'd2);
      nxt(); smp();
      chk($sformatf("s_b%0d", k), {31'd0, ramREN}, 0);
    end
    nxt(); smp();
    chk("s_after", {30'd0, ihit, dhit}, 1);
    nxt();
    iREN      = 1'b0;
    dREN      = 1'b0;
    ram_ready = 1'b0;
    smp();
    chk("s_end", {31'd0, ramREN}, 0);

    // abort: fetch dropped mid-grant
    nxt();
    iREN  = 1'b1;
    iaddr = 32'h80;
    nxt(); smp();
    chk("a1_ren", {31'd0, ramREN}, 1);
    nxt();
    iREN      = 1'b0;
    ram_ready = 1'b1;
    smp();
    chk("a2_ren", {31'd0, ramREN}, 0);
    chk("a2_ihit", {31'd0, ihit}, 0);
    nxt();
    ram_ready = 1'b0;
    iREN      = 1'b1;
    smp();
    chk("a3_idle", {31'd0, ramREN}, 0);
    nxt();
    ram_ready = 1'b1;
    ramload   = 32'h55;
    smp();
    chk("a4_ihit", {31'd0, ihit}, 1);
    nxt();
    ram_ready = 1'b0;
    iREN      = 1'b0;

    // reset mid-access
    nxt();
    dREN  = 1'b1;
    daddr = 32'h300;
    nxt(); smp();
    chk("r1_ren", {31'd0, ramREN}, 1);
    nxt();
    RST       = 1'b1;
    ram_ready = 1'b1;
    smp();
    chk("r2_dhit", {31'd0, dhit}, 0);
    chk("r2_ren", {31'd0, ramREN}, 0);
    nxt();
    RST       = 1'b0;
    dREN      = 1'b0;
    ram_ready = 1'b0;
    smp();
    chk("r3_ren", {31'd0, ramREN}, 0);

    // grant with ram_ready never asserted
    nxt();
    iREN  = 1'b1;
    iaddr = 32'hC0;
    for (int c = 1; c <= 8; c++) begin
      nxt(); smp();
      chk($sformatf("t_g%0d", c), {31'd0, ramREN}, 1);
    end
    nxt(); smp();
`ifdef MEM_ARB_TIMEOUT_EN
    chk("t_idle", {31'd0, ramREN}, 0);
    chk("t_err", {31'd0, arb_err}, 1);
    nxt(); smp();
    chk("t_retry", {31'd0, ramREN}, 1);
    chk("t_sticky", {31'd0, arb_err}, 1);
    nxt();
    iREN = 1'b0;
    RST  = 1'b1;
    nxt();
    RST = 1'b0;
    smp();
    chk("t_clr", {31'd0, arb_err}, 0);
`else
    chk("t_hold", {31'd0, ramREN}, 1);
    chk("t_err", {31'd0, arb_err}, 0);
    for (int c = 0; c < 20; c++) begin
      nxt();
    end
    smp();
    chk("t_hold2", {31'd0, ramREN}, 1);
    chk("t_err2", {31'd0, arb_err}, 0);
    nxt();
    iREN = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
